// File: rtl/code_conv_sched_if.sv
// Requester/converter bundle for code_conv_sched; master = scheduler, slave = requesters + converter.
interface code_conv_sched_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [4*NREQ-1:0] req_in;
   logic [2*NREQ-1:0] req_sel;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [7:0]        rsp_data;
   logic              rsp_err;
   logic              conv_start;
   logic [3:0]        conv_in;
   logic [1:0]        conv_sel;
   logic              conv_done;
   logic [7:0]        conv_result;
   logic              busy;
   logic [IDW-1:0]    grant_id;

   modport master (
      input  req_valid, req_in, req_sel, conv_done, conv_result,
      output req_ready, rsp_valid, rsp_data, rsp_err,
             conv_start, conv_in, conv_sel, busy, grant_id
   );

   modport slave (
      output req_valid, req_in, req_sel, conv_done, conv_result,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
             conv_start, conv_in, conv_sel, busy, grant_id
   );
endinterface

// File: rtl/code_conv_sched.sv
// Round-robin scheduler sharing one gray/BCD/excess-3 converter among NREQ requesters.
// Optional WAIT-state abort counter enabled by defining CONV_TIMEOUT_EN.
module code_conv_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
`ifdef CONV_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 15
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   code_conv_sched_if.master      bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          r_state;
   logic [NREQ-1:0] r_req_ready;
   logic [NREQ-1:0] r_rsp_valid;
   logic [7:0]      r_rsp_data;
   logic            r_rsp_err;
   logic [7:0]      r_res_data;
   logic            r_res_err;
   logic            r_conv_start;
   logic [3:0]      r_conv_in;
   logic [1:0]      r_conv_sel;
   logic            r_busy;
   logic [IDW-1:0]  r_grant;
   logic [IDW-1:0]  r_ptr;

   logic [3:0]      w_in  [NREQ];
   logic [1:0]      w_sel [NREQ];
   logic            w_found;
   logic [IDW-1:0]  w_win;

`ifdef CONV_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]   r_cnt;
`endif

   for (genvar g = 0; g < NREQ; g++) begin : g_split
      assign w_in[g]  = bus.req_in[4*g +: 4];
      assign w_sel[g] = bus.req_sel[2*g +: 2];
   end

   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return IDW'(s);
   endfunction

   // First pending requester at or after the priority pointer, wrapping around.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!w_found && bus.req_valid[rr_idx(r_ptr, k)]) begin
            w_found = 1'b1;
            w_win   = rr_idx(r_ptr, k);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_req_ready  <= '0;
         r_rsp_valid  <= '0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_res_data   <= '0;
         r_res_err    <= 1'b0;
         r_conv_start <= 1'b0;
         r_conv_in    <= '0;
         r_conv_sel   <= '0;
         r_busy       <= 1'b0;
         r_grant      <= '0;
         r_ptr        <= '0;
`ifdef CONV_TIMEOUT_EN
         r_cnt        <= '0;
`endif
      end else begin
         r_req_ready  <= '0;
         r_rsp_valid  <= '0;
         r_conv_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_req_ready[w_win] <= 1'b1;
                  r_grant            <= w_win;
                  r_conv_in          <= w_in[w_win];
                  r_conv_sel         <= w_sel[w_win];
                  r_busy             <= 1'b1;
                  // Illegal select never reaches the converter.
                  if (w_sel[w_win] == 2'd3) begin
                     r_res_data <= 8'h00;
                     r_res_err  <= 1'b1;
                     r_state    <= S_RESP;
                  end else begin
                     r_state    <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_conv_start <= 1'b1;
`ifdef CONV_TIMEOUT_EN
               r_cnt        <= '0;
`endif
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.conv_done) begin
                  r_res_data <= bus.conv_result;
                  r_res_err  <= 1'b0;
                  r_state    <= S_RESP;
               end
`ifdef CONV_TIMEOUT_EN
               else if (r_cnt == CW'(TIMEOUT - 1)) begin
                  r_res_data <= 8'hFF;
                  r_res_err  <= 1'b1;
                  r_state    <= S_RESP;
               end else begin
                  r_cnt      <= r_cnt + CW'(1);
               end
`endif
            end
            S_RESP: begin
               r_rsp_valid[r_grant] <= 1'b1;
               r_rsp_data           <= r_res_data;
               r_rsp_err            <= r_res_err;
               r_ptr                <= (r_grant == IDW'(NREQ - 1)) ? '0 : r_grant + IDW'(1);
               r_busy               <= 1'b0;
               r_state              <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data   = r_rsp_data;
   assign bus.rsp_err    = r_rsp_err;
   assign bus.conv_start = r_conv_start;
   assign bus.conv_in    = r_conv_in;
   assign bus.conv_sel   = r_conv_sel;
   assign bus.busy       = r_busy;
   assign bus.grant_id   = r_grant;

endmodule

// File: tb/tb_code_conv_sched.sv
// Bench for code_conv_sched: directed scenarios plus random traffic against a transaction-level model.
module tb_code_conv_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic            clk = 1'b0;
   logic            rst;
   int              n_checks = 0;
   int              n_errs   = 0;
   int              ptr_m;
   logic [3:0]      op [NREQ];
   logic [1:0]      sl [NREQ];
   logic [NREQ-1:0] vmask;
   logic [7:0]      last_d;
   logic            last_e;

   code_conv_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
   code_conv_sched #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      bus.req_in    = {op[3], op[2], op[1], op[0]};
      bus.req_sel   = {sl[3], sl[2], sl[1], sl[0]};
      bus.req_valid = vmask;
   endtask

   // Converter behaviour: gray, two-digit BCD, excess-3.
   function automatic logic [7:0] conv_ref(input logic [3:0] x, input logic [1:0] s);
      int v;
      v = int'(x);
      case (s)
         2'd0:    return 8'(v ^ (v >> 1));
         2'd1:    return 8'((v / 10) * 16 + (v % 10));
         2'd2:    return 8'(v + 3);
         default: return 8'h00;
      endcase
   endfunction

   task automatic check_zero_outs(input string tag);
      check({tag, "_rdy"},   bus.req_ready,  0);
      check({tag, "_rsp"},   bus.rsp_valid,  0);
      check({tag, "_data"},  bus.rsp_data,   0);
      check({tag, "_err"},   bus.rsp_err,    0);
      check({tag, "_start"}, bus.conv_start, 0);
      check({tag, "_busy"},  bus.busy,       0);
      check({tag, "_gid"},   bus.grant_id,   0);
   endtask

   // One full transaction from an IDLE DUT; vmask must be non-zero.
   task automatic do_txn(input int lat, input bit spur);
      int         win;
      logic [3:0] one;
      logic [7:0] exp_d;
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (ptr_m + k) % NREQ;
         if (win < 0 && vmask[i]) win = i;
      end
      one = 4'(1 << win);
      drive();
      tick();
      check("req_ready", bus.req_ready, one);
      check("grant_id",  bus.grant_id, win);
      check("busy_acc",  bus.busy, 1);
      check("conv_in",   bus.conv_in, op[win]);
      check("conv_sel",  bus.conv_sel, sl[win]);
      check("start_acc", bus.conv_start, 0);
      check("data_hold", bus.rsp_data, last_d);
      check("err_hold",  bus.rsp_err, last_e);
      ptr_m = (win + 1) % NREQ;
      if (sl[win] == 2'd3) begin
         tick();
         check("ill_rsp",   bus.rsp_valid, one);
         check("ill_err",   bus.rsp_err, 1);
         check("ill_data",  bus.rsp_data, 0);
         check("ill_start", bus.conv_start, 0);
         check("ill_busy",  bus.busy, 0);
         last_d = 8'h00;
         last_e = 1'b1;
         return;
      end
      if (spur) begin
         bus.conv_done   = 1'b1;
         bus.conv_result = 8'hA5;
      end
      tick();
      bus.conv_done = 1'b0;
      check("conv_start", bus.conv_start, 1);
      check("rdy_issue",  bus.req_ready, 0);
      check("rsp_issue",  bus.rsp_valid, 0);
      exp_d = conv_ref(op[win], sl[win]);
      for (int j = 1; j <= lat; j++) begin
         if (j == lat) begin
            bus.conv_done   = 1'b1;
            bus.conv_result = conv_ref(bus.conv_in, bus.conv_sel);
         end
         tick();
         bus.conv_done = 1'b0;
         check("start_wait", bus.conv_start, 0);
         check("rsp_wait",   bus.rsp_valid, 0);
         check("busy_wait",  bus.busy, 1);
      end
      tick();
      check("rsp_valid", bus.rsp_valid, one);
      check("rsp_data",  bus.rsp_data, exp_d);
      check("rsp_err",   bus.rsp_err, 0);
      check("busy_done", bus.busy, 0);
      last_d = exp_d;
      last_e = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      vmask           = '0;
      bus.conv_done   = 1'b0;
      bus.conv_result = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         op[i] = 4'(i);
         sl[i] = 2'd0;
      end
      drive();
      ptr_m  = 0;
      last_d = 8'h00;
      last_e = 1'b0;
      #1;
      check_zero_outs("reset");
      check("reset_in", bus.conv_in, 0);
      tick();
      tick();
      rst = 1'b0;

      // Round-robin with all requesters continuously valid.
      vmask = 4'b1111;
      for (int t = 0; t < 5; t++) do_txn(2, 1'b0);

      // Single BCD request, converter answers three cycles after start.
      vmask = 4'b0001;
      op[0] = 4'hD;
      sl[0] = 2'd1;
      do_txn(3, 1'b0);
      check("bcd_value", bus.rsp_data, 8'h13);

      // Illegal select from requester 2.
      vmask = 4'b0100;
      sl[2] = 2'd3;
      do_txn(1, 1'b0);

      // Leave pointer at 3, then reset while requester 1 is in WAIT.
      vmask = 4'b0100;
      op[2] = 4'h9;
      sl[2] = 2'd2;
      do_txn(2, 1'b0);
      vmask = 4'b0010;
      op[1] = 4'h7;
      sl[1] = 2'd1;
      drive();
      tick();
      check("rw_gid", bus.grant_id, 1);
      tick();
      check("rw_start", bus.conv_start, 1);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check_zero_outs("rst_wait");
      for (int t = 0; t < 2; t++) begin
         tick();
         check("rst_hold_rsp",  bus.rsp_valid, 0);
         check("rst_hold_busy", bus.busy, 0);
      end
      rst    = 1'b0;
      ptr_m  = 0;
      last_d = 8'h00;
      last_e = 1'b0;
      vmask  = 4'b1111;
      sl[1]  = 2'd0;
      do_txn(1, 1'b0);

`ifdef CONV_TIMEOUT_EN
      // Converter never answers: abort after 15 WAIT cycles.
      vmask = 4'b1000;
      op[3] = 4'h6;
      sl[3] = 2'd0;
      drive();
      tick();
      check("to_rdy", bus.req_ready, 4'b1000);
      ptr_m = 0;
      tick();
      check("to_start", bus.conv_start, 1);
      vmask = '0;
      drive();
      for (int t = 0; t < 15; t++) begin
         tick();
         check("to_wait_rsp",  bus.rsp_valid, 0);
         check("to_wait_busy", bus.busy, 1);
      end
      tick();
      check("to_rsp",  bus.rsp_valid, 4'b1000);
      check("to_data", bus.rsp_data, 8'hFF);
      check("to_err",  bus.rsp_err, 1);
      bus.conv_done   = 1'b1;
      bus.conv_result = 8'h3C;
      tick();
      bus.conv_done = 1'b0;
      check("late_rsp",  bus.rsp_valid, 0);
      check("late_busy", bus.busy, 0);
      check("late_data", bus.rsp_data, 8'hFF);
      last_d = 8'hFF;
      last_e = 1'b1;
`endif

      // Random traffic, including dropped requests and idle cycles.
      for (int t = 0; t < 200; t++) begin
         vmask = 4'($urandom_range(0, 15));
         for (int i = 0; i < NREQ; i++) begin
            op[i] = 4'($urandom_range(0, 15));
            sl[i] = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         end
         if (vmask == '0) begin
            drive();
            tick();
            check("idle_rdy",  bus.req_ready, 0);
            check("idle_busy", bus.busy, 0);
         end else begin
            do_txn(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/code_conv_sched.md
# code_conv_sched

Round-robin scheduler that shares one code-converter datapath (gray / BCD / excess-3) among `NREQ` requesters. It accepts one request at a time, drives the converter's `start`/`in`/`sel` handshake, and waits for the converter's `done`. It then returns the captured 8-bit result to the winning requester. It sits between the requester ports and the converter instance in the top level.

## Interface
- `NREQ`, default 4: number of requesters; 2..8.
- `IDW`, default 2: width of `grant_id`; equals clog2(`NREQ`).
- `TIMEOUT`, default 15: maximum number of WAIT cycles before abort (used only with `CONV_TIMEOUT_EN`).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in `NREQ`: request pending per requester. Held until `req_ready`.
- `req_in` in 4*`NREQ`: operand; requester i uses bits [4i+3:4i].
- `req_sel` in 2*`NREQ`: conversion select. 0 = gray, 1 = BCD, 2 = excess-3, 3 = illegal.
- `req_ready` out `NREQ`: one-hot, 1-cycle accept pulse.
- `rsp_valid` out `NREQ`: one-hot, 1-cycle result pulse, sent to the accepted requester.
- `rsp_data` out 8: result. Valid with `rsp_valid` and held until the next response.
- `rsp_err` out 1: error flag. Valid with `rsp_valid` and held with `rsp_data`.
- `conv_start` out 1: converter start pulse.
- `conv_in` out 4: converter operand. Held from ISSUE through WAIT.
- `conv_sel` out 2: converter select. Held from ISSUE through WAIT.
- `conv_done` in 1: converter completion.
- `conv_result` in 8: converter result. Sampled when `conv_done` is high.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out `IDW`: index of the current or last granted requester.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` bit is set, arbitrate round-robin starting at the priority pointer.
  - Latch the winner's `req_in`/`req_sel` into `conv_in`/`conv_sel` and set `grant_id`.
  - Pulse `req_ready[winner]` in the same cycle.
  - If the latched sel is 3, go to RESP with err=1 and data=8'h00; `conv_start` is never asserted. Otherwise go to ISSUE.
- ISSUE: assert `conv_start` for exactly one cycle, then go to WAIT. `conv_done` is ignored in ISSUE.
- WAIT: when `conv_done`=1, capture `conv_result` into `rsp_data`, set err=0, and go to RESP.
- RESP:
  - Assert `rsp_valid[grant_id]` for one cycle.
  - Set the priority pointer to (`grant_id`+1) mod `NREQ`.
  - Return to IDLE.
- Arbitration: the pointer resets to 0. Requester 0 has highest priority after reset. A newly arriving request never preempts a request in flight.
- A requester that drops `req_valid` before `req_ready` is simply not granted; this is legal.
- `req_valid` bits asserted during ISSUE, WAIT or RESP wait for the next IDLE cycle.
- Reset, asynchronous and at any time (including mid-WAIT):
  - State returns to IDLE; the pointer, `grant_id`, `rsp_data` and `rsp_err` clear to 0.
  - Any in-flight response is dropped; no `rsp_valid` is issued.
  - All outputs read 0 while `rst` is high.

## Timing
- Cycle 0 (IDLE): request accepted; `req_ready` pulses.
- Cycle 1 (ISSUE): `conv_start` = 1.
- Cycle 2 onward (WAIT): waiting for the converter.
- If `conv_done` is sampled at cycle k (k ≥ 2), `rsp_valid` is asserted at cycle k+1.
- The earliest next acceptance is cycle k+2.
- Illegal sel: `rsp_valid` is asserted at cycle 1 and the next acceptance is at cycle 2.
- Throughput: one conversion in flight at a time, with no back-to-back overlap.
- All outputs are registered.

## Configuration
- `CONV_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT and clears on entry to WAIT.
  - After `TIMEOUT` WAIT cycles with no `conv_done`, go to RESP with err=1 and `rsp_data`=8'hFF.
  - A `conv_done` arriving after the abort is ignored while in RESP or IDLE.
- `CONV_TIMEOUT_EN` undefined: WAIT has no exit other than `conv_done`, and no counter logic is present.

## Test plan
- Single request, BCD conversion:
  - Stimulus: `req_valid`=4'b0001, `req_in[3:0]`=4'b1101, sel=1. The converter model returns 8'h13 three cycles after start.
  - Required: `req_ready`[0] at cycle 0, `conv_start` at cycle 1, `conv_in`=4'hD, `conv_sel`=1.
  - Required: `rsp_valid`[0] with `rsp_data`=8'h13 and `rsp_err`=0.
- Round-robin ordering:
  - Stimulus: all four requesters valid continuously; each operand = its index; sel=0.
  - Required: grants in order 0, 1, 2, 3, 0; each `rsp_valid` one-hot matches its grant.
  - Required: no `conv_start` while `busy` from a prior grant.
- Illegal select:
  - Stimulus: requester 2 with sel=3.
  - Required: `req_ready`[2] at cycle 0, then `rsp_valid`[2] at cycle 1 with `rsp_err`=1 and `rsp_data`=8'h00.
  - Required: `conv_start` never asserts.
- Timeout (build with `CONV_TIMEOUT_EN`, `TIMEOUT`=15):
  - Stimulus: converter model never asserts done.
  - Required: `rsp_valid` with `rsp_err`=1 and `rsp_data`=8'hFF exactly 15 WAIT cycles after entering WAIT.
- Reset mid-WAIT:
  - Stimulus: assert `rst` between clock edges during WAIT.
  - Required: `busy`, `conv_start`, `rsp_valid`, `rsp_data` and `grant_id` go to 0 immediately.
  - Required: after release, requester 0 wins first even if the prior grant was 0.
